// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter for one NOC router output.
// Locks the grant for a whole wormhole packet of PKT_FLITS flits and muxes the
// granted port onto the output channel with zero latency.
module noc_rr_arbiter #(
    parameter int unsigned N_PORTS    = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_FLITS  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_PORTS-1:0]              in_valid_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_data_i,
    output logic [N_PORTS-1:0]              in_ready_o,
    output logic                            out_valid_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    input  logic                            out_ready_i,
    output logic [N_PORTS-1:0]              grant_o,
    output logic                            busy_o,
    output logic                            pt_inc_o,
    output logic                            pkt_done_o
);

    localparam int unsigned PTR_W = $clog2(N_PORTS);
    localparam int unsigned CNT_W = $clog2(PKT_FLITS);
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_FLITS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_PORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e             state_q;
    logic [N_PORTS-1:0] grant_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               req_any_c;
    logic [PTR_W-1:0]   winner_c;
    logic               xfer_c;
    logic               tail_c;

    // Round-robin scan: first requester at or after ptr_q, wrapping modulo N_PORTS
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        req_any_c = 1'b0;
        winner_c  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx = {1'b0, ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(N_PORTS)) begin
                idx = idx - IDX_W'(N_PORTS);
            end
            if (!req_any_c && in_valid_i[PTR_W'(idx)]) begin
                req_any_c = 1'b1;
                winner_c  = PTR_W'(idx);
            end
        end
    end

    // Granted-port datapath; grant_q is zero outside LOCK so everything idles at 0
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        in_ready_o  = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (grant_q[p]) begin
                out_valid_o   = in_valid_i[p];
                out_data_o    = in_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                in_ready_o[p] = out_ready_i;
            end
        end
        xfer_c = out_valid_o & out_ready_i;
        tail_c = xfer_c & (cnt_q == CNT_LAST);
    end

    assign pt_inc_o   = xfer_c;
    assign pkt_done_o = tail_c;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == LOCK);

    // Arbitration / packet-lock state machine
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any_c) begin
                        grant_q <= N_PORTS'(1) << winner_c;
                        ptr_q   <= (winner_c == PTR_LAST) ? '0 : winner_c + PTR_W'(1);
                        cnt_q   <= '0;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (tail_c) begin
                        cnt_q   <= '0;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (xfer_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter with a flit scoreboard and a reference model.
module tb_noc_rr_arbiter;

    localparam int N   = 5;
    localparam int W   = 32;
    localparam int PKT = 5;

    logic             clk;
    logic             reset;
    logic [N-1:0]     in_valid_i;
    logic [N*W-1:0]   in_data_i;
    logic [N-1:0]     in_ready_o;
    logic             out_valid_o;
    logic [W-1:0]     out_data_o;
    logic             out_ready_i;
    logic [N-1:0]     grant_o;
    logic             busy_o;
    logic             pt_inc_o;
    logic             pkt_done_o;

    noc_rr_arbiter #(
        .N_PORTS    (N),
        .DATA_WIDTH (W),
        .PKT_FLITS  (PKT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .pt_inc_o    (pt_inc_o),
        .pkt_done_o  (pkt_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp;
    int          n_err;
    int          n_pulse;
    int          src_cnt [N];
    logic [W-1:0] sb_q [$];
    logic        in_rst;

    // reference model state
    logic        m_busy;
    int          m_port;
    int          m_ptr;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] flit_word(input int p, input int c);
        return {8'(p + 1), 24'(c)};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        int idx;
        int win;
        win = -1;
        for (int i = 0; i < N; i++) begin
            idx = (ptr + i) % N;
            if (win < 0 && req[idx]) win = idx;
        end
        return win;
    endfunction

    task automatic drive_data();
        for (int p = 0; p < N; p++) in_data_i[p*W +: W] = flit_word(p, src_cnt[p]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},    64'(grant_o),     64'(0));
        check({tag, "_busy"},     64'(busy_o),      64'(0));
        check({tag, "_pt_inc"},   64'(pt_inc_o),    64'(0));
        check({tag, "_pkt_done"}, 64'(pkt_done_o),  64'(0));
        check({tag, "_in_ready"}, 64'(in_ready_o),  64'(0));
        check({tag, "_out_valid"},64'(out_valid_o), 64'(0));
        check({tag, "_out_data"}, 64'(out_data_o),  64'(0));
    endtask

    // One clock: sample/check at negedge, advance model, return at posedge+1
    task automatic cycle();
        logic         exp_xfer;
        logic [N-1:0] exp_gnt;
        int           w;
        @(negedge clk);
        if (pt_inc_o) n_pulse++;
        if (in_rst) begin
            check_all_zero("in_reset");
        end else begin
            exp_gnt  = m_busy ? (N'(1) << m_port) : '0;
            exp_xfer = m_busy && in_valid_i[m_port] && out_ready_i;
            check("grant",     64'(grant_o),     64'(exp_gnt));
            check("busy",      64'(busy_o),      64'(m_busy));
            check("out_valid", 64'(out_valid_o), 64'(m_busy && in_valid_i[m_port]));
            check("in_ready",  64'(in_ready_o),  64'((m_busy && out_ready_i) ? exp_gnt : '0));
            check("pt_inc",    64'(pt_inc_o),    64'(exp_xfer));
            check("pkt_done",  64'(pkt_done_o),  64'(exp_xfer && (m_cnt == PKT - 1)));
            if (m_busy && in_valid_i[m_port]) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    check("out_data", 64'(out_data_o), 64'(sb_q[0]));
                    if (exp_xfer) void'(sb_q.pop_front());
                end
            end else if (!m_busy) begin
                check("out_data_idle", 64'(out_data_o), 64'(0));
            end
            if (exp_xfer) begin
                src_cnt[m_port]++;
                if (m_cnt == PKT - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else if (!m_busy && in_valid_i != '0) begin
                w      = rr_pick(m_ptr, in_valid_i);
                m_port = w;
                m_ptr  = (w + 1) % N;
                m_cnt  = 0;
                m_busy = 1'b1;
                for (int k = 0; k < PKT; k++) sb_q.push_back(flit_word(w, src_cnt[w] + k));
            end
        end
        @(posedge clk);
        #1;
        drive_data();
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_port = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        sb_q.delete();
    endtask

    initial begin
        int p0;
        n_cmp   = 0;
        n_err   = 0;
        n_pulse = 0;
        for (int p = 0; p < N; p++) src_cnt[p] = 0;
        model_reset();
        in_rst      = 1'b1;
        reset       = 1'b0;
        in_valid_i  = '0;
        out_ready_i = 1'b0;
        drive_data();

        // power-on reset
        repeat (3) cycle();
        check_all_zero("reset");
        reset  = 1'b1;
        in_rst = 1'b0;

        // T2: single requester, port 2
        in_valid_i  = 5'b00100;
        out_ready_i = 1'b1;
        cycle();
        check("t2_grant", 64'(grant_o), 64'(5'b00100));
        p0 = n_pulse;
        repeat (5) cycle();
        check("t2_pulses", 64'(n_pulse - p0), 64'(5));
        check("t2_grant_after", 64'(grant_o), 64'(0));

        // T1: reset mid-packet at cnt=2 (port 3 holds the grant)
        in_valid_i = 5'b11111;
        cycle();
        check("t1_grant", 64'(grant_o), 64'(5'b01000));
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t1_async");
        model_reset();
        in_rst = 1'b1;
        repeat (2) cycle();
        reset  = 1'b1;
        in_rst = 1'b0;

        // T3: all ports requesting, order 0,1,2,3,4,0 with one idle cycle between
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t3_grant", 64'(grant_o), 64'(N'(1) << (k % N)));
            repeat (5) cycle();
            check("t3_idle_after_tail", 64'(busy_o), 64'(0));
        end
        in_valid_i = '0;
        cycle();

        // T4: downstream stalls every other cycle, port 1
        in_valid_i = 5'b00010;
        cycle();
        check("t4_grant", 64'(grant_o), 64'(5'b00010));
        p0 = n_pulse;
        for (int i = 0; i < 9; i++) begin
            out_ready_i = (i % 2 == 0);
            cycle();
        end
        in_valid_i  = '0;
        out_ready_i = 1'b1;
        cycle();
        check("t4_pulses", 64'(n_pulse - p0), 64'(5));
        check("t4_sb_drained", 64'(sb_q.size()), 64'(0));

        // T5: granted port 4 bubbles for 3 cycles while port 1 requests
        in_valid_i = 5'b10000;
        cycle();
        check("t5_grant", 64'(grant_o), 64'(5'b10000));
        cycle();
        cycle();
        in_valid_i = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_hold", 64'(grant_o), 64'(5'b10000));
            check("t5_p1_ready", 64'(in_ready_o[1]), 64'(0));
        end
        in_valid_i = 5'b10010;
        repeat (3) cycle();
        check("t5_done_idle", 64'(busy_o), 64'(0));
        in_valid_i = 5'b00010;
        cycle();
        check("t5_next_grant", 64'(grant_o), 64'(5'b00010));
        repeat (5) cycle();
        in_valid_i = '0;
        cycle();

        // T6: steer ptr to 3 via port 2, then 00011 wraps to port 0 and ptr becomes 1
        in_valid_i = 5'b00100;
        cycle();
        check("t6_setup_grant", 64'(grant_o), 64'(5'b00100));
        repeat (5) cycle();
        in_valid_i = 5'b00011;
        cycle();
        check("t6_wrap_grant", 64'(grant_o), 64'(5'b00001));
        repeat (5) cycle();
        cycle();
        check("t6_ptr_one", 64'(grant_o), 64'(5'b00010));
        repeat (5) cycle();
        in_valid_i = '0;
        repeat (2) cycle();
        check("final_sb_drained", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
